// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and defaults for the memory request controller
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - bounded wait counter that flags expiry after TIMEOUT+1 waiting cycles
module wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT; the controller leaves the wait state on the cycle expired is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - request/response controller driving the 32x8 data memory pins
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  logic   timer_clear;
  logic   timer_enable;
  logic   timer_expired;

  assign timer_clear  = (state == RD_REQ) || (state == WR_REQ);
  assign timer_enable = (state == RD_WAIT) || (state == WR_WAIT);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // mem_addr/mem_wdata double as the request latch and hold their value between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (req_we) begin
              mem_wr <= 1'b1;
              state  <= WR_REQ;
            end else begin
              mem_rd <= 1'b1;
              state  <= RD_REQ;
            end
          end
        end
        RD_REQ: state <= RD_WAIT;
        WR_REQ: begin
          mem_wr <= 1'b0;
          state  <= WR_WAIT;
        end
        RD_WAIT, WR_WAIT: begin
          // Only a clean 1 counts as ready; X/Z fall through to the timeout path.
          if (mem_ready == 1'b1) begin
            if (state == RD_WAIT) rsp_rdata <= mem_rdata;
            rsp_err   <= 1'b0;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer_expired) begin
            rsp_err   <= 1'b1;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl against a transaction-level model
module tb_mem_req_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Behavioural data memory: commits on the closing edge of a cycle with mem_wr high.
  logic [DW-1:0] bmem [32];
  always @(posedge clk) if (mem_wr === 1'b1) bmem[mem_addr] <= mem_wdata;
  always_comb mem_rdata = (mem_rd === 1'b1) ? bmem[mem_addr] : 'z;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rdata = '0;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request; delay = WAIT cycles before mem_ready=1, negative means never ready.
  task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int delay, input bit hold, input bit zidle, output int rsp_cyc);
    int   lat;
    logic nr;
    nr      = zidle ? 1'bz : 1'b0;
    lat     = 3 + ((delay < 0) ? TO : delay);
    rsp_cyc = -1;
    if (we) ref_mem[addr] = wdata;
    else if (delay >= 0) exp_rdata = ref_mem[addr];
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    mem_ready = (delay == 0) ? 1'b1 : nr;
    tick;
    if (!hold) req_valid = 1'b0;
    for (int n = 1; n <= lat; n++) begin
      mem_ready = (delay >= 0 && (n >= delay + 2 || delay == 0)) ? 1'b1 : nr;
      chk("req_ready_busy", req_ready, 0);
      chk("rsp_valid", rsp_valid, (n == lat));
      chk("mem_rd", mem_rd, (!we && n < lat));
      chk("mem_wr", mem_wr, (we && n == 1));
      chk("mem_addr", mem_addr, addr);
      if (we) chk("mem_wdata", mem_wdata, wdata);
      if (n == lat) begin
        rsp_cyc = cyc;
        chk("rsp_err", rsp_err, (delay < 0));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
      tick;
    end
    mem_ready = 1'b0;
    chk("req_ready_after", req_ready, 1);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("mem_rd_after", mem_rd, 0);
    chk("rsp_rdata_held", rsp_rdata, exp_rdata);
  endtask

  initial begin
    int            rc;
    int            t1;
    int            t2;
    int            dly;
    logic [DW-1:0] old9;

    // Reset held with a pending write request: nothing may reach the memory.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd5;
    req_wdata = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_mem_wr", mem_wr, 0);

    for (int a = 0; a < 32; a++) txn(1'b1, AW'(a), DW'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, rc);

    txn(1'b0, 5'h1F, 8'h00, 0, 1'b1, 1'b0, t1);
    txn(1'b0, 5'h00, 8'h00, 0, 1'b0, 1'b0, t2);
    chk("b2b_spacing", t2 - t1, 4);

    txn(1'b1, 5'd5, 8'hA7, 0, 1'b0, 1'b0, rc);
    txn(1'b0, 5'd5, 8'h00, 0, 1'b0, 1'b0, rc);
    chk("read_back_a7", rsp_rdata, 8'hA7);

    txn(1'b0, 5'd3, 8'h00, -1, 1'b0, 1'b0, rc);
    chk("timeout_rdata_kept", rsp_rdata, 8'hA7);

    txn(1'b0, 5'd12, 8'h00, 3, 1'b0, 1'b1, rc);

    // Reset lands while WR_REQ is driving mem_wr.
    old9      = ref_mem[9];
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd9;
    req_wdata = ~old9;
    tick;
    req_valid = 1'b0;
    chk("midwr_mem_wr_before", mem_wr, 1);
    rst = 1'b0;
    #1;
    chk("midwr_mem_wr_drop", mem_wr, 0);
    chk("midwr_rsp_valid", rsp_valid, 0);
    tick;
    tick;
    rst = 1'b1;
    exp_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("midwr_no_rsp", rsp_valid, 0);
    end
    chk("midwr_rdata_cleared", rsp_rdata, 0);
    txn(1'b0, 5'd9, 8'h00, 1, 1'b0, 1'b0, rc);
    chk("midwr_old_value", rsp_rdata, old9);

    for (int i = 0; i < 40; i++) begin
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
      txn(1'($urandom), AW'($urandom), DW'($urandom), dly, 1'b0, 1'($urandom), rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
